hazard_ctrl: RTL and testbench

- Central pipeline hazard controller for the 5-stage RISC-V core.
- Generates the stall, flush and bubble controls for the PC register, the fetch/decode instruction register and the ID/EX register.
- Drives the fetch/decode register's squash input (ifid_flush) on taken branches.
- Inserts load-use bubbles, freezes the pipe on data-memory wait, and times out stuck memory accesses.

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash, data-memory wait and timeout.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  ex_stall,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
);

  // state    | meaning
  // RUN      | normal flow; mem_busy > branch_taken > load-use
  // MEM_WAIT | data memory busy, counting toward timeout
  // FLUSH    | squashing fetch/decode for the remaining post-branch cycles
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] to_cnt, to_cnt_nxt;
  logic       lu, run_eval;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    to_cnt_nxt    = to_cnt;
    run_eval      = 1'b0;
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    ex_stall      = 1'b0;
    mem_err       = 1'b0;

    case (state)
      RUN: run_eval = 1'b1;
      MEM_WAIT: begin
        if (mem_busy) begin
          if (to_cnt < TO_LAST) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            ex_stall   = 1'b1;
            to_cnt_nxt = to_cnt + 8'd1;
          end else begin
            mem_err   = 1'b1;
            state_nxt = RUN;
          end
        end else begin
          // the cycle memory completes is also a normal RUN decision cycle
          state_nxt = RUN;
          run_eval  = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (mem_busy) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          ex_stall   = 1'b1;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
          if (flush_cnt == 4'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (run_eval) begin
      if (mem_busy) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        ex_stall   = 1'b1;
        to_cnt_nxt = 8'd1;
        state_nxt  = MEM_WAIT;
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          flush_cnt_nxt = FL_INIT;
          state_nxt     = FLUSH;
        end
      end else if (lu) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end

    // outputs are combinational, so they must be forced low while reset is held
    if (!rstn) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ex_stall    = 1'b0;
      mem_err     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
      to_cnt    <= 8'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (pc_stall)   stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush) flush_cycles <= flush_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use vector table plus multi-cycle branch/memory/reset sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_stall, mem_err;
  logic [31:0] stall_cycles, flush_cycles;

  int n_chk = 0;
  int n_fail = 0;

  // packed view: {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_stall, mem_err}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_LU    = 6'b110100;
  localparam logic [5:0] O_STALL = 6'b110010;
  localparam logic [5:0] O_FLUSH = 6'b001100;
  localparam logic [5:0] O_ERR   = 6'b000001;

  hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ex_stall(ex_stall), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mrd;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_stall, mem_err};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs=%b required=%b", name, got, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: value=%0d required=%0d", name, got, exp);
    end
  endtask

  // inputs are already set; check at negedge, then advance past the next rising edge
  task automatic cyc(input string name, input logic [5:0] exp);
    @(negedge clk);
    chk(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    vecs[0] = '{rs1:5, rs2:0, rd:5,  use1:1, use2:0, mrd:1, exp:O_LU,   name:"lu_rs1"};
    vecs[1] = '{rs1:0, rs2:0, rd:0,  use1:1, use2:0, mrd:1, exp:O_IDLE, name:"lu_rd_zero"};
    vecs[2] = '{rs1:1, rs2:7, rd:7,  use1:0, use2:1, mrd:1, exp:O_LU,   name:"lu_rs2"};
    vecs[3] = '{rs1:5, rs2:0, rd:5,  use1:0, use2:0, mrd:1, exp:O_IDLE, name:"lu_no_use"};
    vecs[4] = '{rs1:5, rs2:5, rd:5,  use1:1, use2:1, mrd:0, exp:O_IDLE, name:"lu_not_load"};
    vecs[5] = '{rs1:4, rs2:6, rd:5,  use1:1, use2:1, mrd:1, exp:O_IDLE, name:"lu_mismatch"};
    vecs[6] = '{rs1:31,rs2:31,rd:31, use1:1, use2:0, mrd:1, exp:O_LU,   name:"lu_rd31"};
    vecs[7] = '{rs1:0, rs2:0, rd:0,  use1:0, use2:0, mrd:0, exp:O_IDLE, name:"lu_idle"};

    // outputs gated low during reset even with active inputs
    branch_taken = 1'b1; mem_busy = 1'b1;
    #2;
    chk("reset_outputs", O_IDLE);
`ifdef HAZ_PERF_CNT_EN
    chk_val("reset_stall_cnt", stall_cycles, 0);
    chk_val("reset_flush_cnt", flush_cycles, 0);
`endif
    idle_inputs();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    cyc("idle_after_reset", O_IDLE);

    for (int i = 0; i < 8; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2; ex_mem_read = vecs[i].mrd;
      cyc(vecs[i].name, vecs[i].exp);
    end

    // branch with a second branch during the squash window
    idle_inputs();
    branch_taken = 1'b1; cyc("br_n", O_FLUSH);
    branch_taken = 1'b1; cyc("br_n1_ignored", O_FLUSH);
    branch_taken = 1'b0; cyc("br_n2", O_IDLE);

    // three-cycle memory wait
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("mw_stall%0d", i), O_STALL);
    mem_busy = 1'b0; cyc("mw_release", O_IDLE);

    // timeout: 15 stall cycles, error on the 16th
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) cyc($sformatf("to_stall%0d", i), O_STALL);
    cyc("to_err", O_ERR);
    mem_busy = 1'b0; cyc("to_back_run", O_IDLE);

    // mem_busy beats branch; held branch then starts flush from MEM_WAIT
    mem_busy = 1'b1; branch_taken = 1'b1; cyc("sim_stall_only", O_STALL);
    mem_busy = 1'b0; cyc("sim_flush0", O_FLUSH);
    branch_taken = 1'b0; cyc("sim_flush1", O_FLUSH);
    cyc("sim_done", O_IDLE);

    // stall inside FLUSH holds the squash count
    branch_taken = 1'b1; cyc("fs_br", O_FLUSH);
    branch_taken = 1'b0; mem_busy = 1'b1; cyc("fs_stall", 6'b111110);
    mem_busy = 1'b0; cyc("fs_last", O_FLUSH);
    cyc("fs_done", O_IDLE);

    // mem_busy beats load-use; load-use re-evaluated after the stall
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    mem_busy = 1'b1; cyc("mlu_stall", O_STALL);
    mem_busy = 1'b0; cyc("mlu_bubble", O_LU);
    idle_inputs(); cyc("mlu_done", O_IDLE);

    // reset while in FLUSH with flush_cnt=1
    branch_taken = 1'b1; cyc("rf_br", O_FLUSH);
    #1 rstn = 1'b0;
    #1 chk("rf_reset_now", O_IDLE);
    @(negedge clk);
    chk("rf_reset_held", O_IDLE);
    idle_inputs();
    rstn = 1'b1;
    @(posedge clk); #1;
    cyc("rf_post0", O_IDLE);
    cyc("rf_post1", O_IDLE);
`ifdef HAZ_PERF_CNT_EN
    chk_val("rf_stall_cnt", stall_cycles, 0);
    chk_val("rf_flush_cnt", flush_cycles, 0);
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    cyc("pc_lu", O_LU);
    idle_inputs();
    @(negedge clk);
    chk_val("pc_stall_cnt", stall_cycles, 1);
    chk_val("pc_flush_cnt", flush_cycles, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
